// File: rtl/ami_bram_responder_if.sv
// AMI port bundle between an initiator (master) and a memory-side responder (slave).
// Request {valid,isWrite,addr[63:0],data[575:0],size[5:0]}; response {valid,data[575:0],size[5:0]}.
interface ami_bram_responder_if;
   logic [647:0] mem_req_in;
   logic         mem_req_in_grant;
   logic [582:0] mem_resp_out;
   logic         mem_resp_out_grant;

   modport master (
      output mem_req_in,
      output mem_resp_out_grant,
      input  mem_req_in_grant,
      input  mem_resp_out
   );

   modport slave (
      input  mem_req_in,
      input  mem_resp_out_grant,
      output mem_req_in_grant,
      output mem_resp_out
   );
endinterface

// File: rtl/ami_bram_responder.sv
// BRAM-backed AMI responder: posted writes, in-order reads with 2-cycle latency,
// first-word fall-through response FIFO guarded by a credit scheme.
module ami_bram_responder #(
   parameter int DEPTH_WORDS  = 1024,
   parameter int ADDR_LSB     = 6,
   parameter int RESP_Q_DEPTH = 4,
   parameter int ERR_CNT_W    = 16
) (
   input  logic                 clk,
   input  logic                 rst_n,
   ami_bram_responder_if.slave  mem_if,
   output logic                 busy,
   output logic [ERR_CNT_W-1:0] err_count
);
   localparam int IDX_W = $clog2(DEPTH_WORDS);
   localparam int PTR_W = (RESP_Q_DEPTH > 1) ? $clog2(RESP_Q_DEPTH) : 1;
   localparam int CNT_W = $clog2(RESP_Q_DEPTH + 1);
   localparam logic [63:0]      LSB_MASK = (64'd1 << ADDR_LSB) - 64'd1;
   localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(RESP_Q_DEPTH - 1);
   localparam logic [CNT_W:0]   Q_DEPTH  = (CNT_W + 1)'(RESP_Q_DEPTH);

   logic         req_valid;
   logic         req_is_write;
   logic [63:0]  req_addr;
   logic [575:0] req_data;
   logic [5:0]   req_size;
   assign {req_valid, req_is_write, req_addr, req_data, req_size} = mem_if.mem_req_in;

   logic [IDX_W-1:0] req_idx;
   logic             req_in_range;
   assign req_idx      = req_addr[ADDR_LSB +: IDX_W];
   assign req_in_range = ((req_addr >> (ADDR_LSB + IDX_W)) == 64'd0) &&
                         ((req_addr & LSB_MASK) == 64'd0);

   logic s1_valid_q, s2_valid_q;
   logic s1_oor_q, s2_oor_q;
   logic [IDX_W-1:0] s1_idx_q;
   logic [5:0] s1_size_q, s2_size_q;
   logic [CNT_W-1:0] count_q, count_d;
   logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
   logic [ERR_CNT_W-1:0] err_count_q;

   // Grant looks only at occupancy plus reads still in the pipe, never at the request.
   logic [CNT_W:0] in_flight, used;
   assign in_flight = {{CNT_W{1'b0}}, s1_valid_q} + {{CNT_W{1'b0}}, s2_valid_q};
   assign used      = {1'b0, count_q} + in_flight;
   assign mem_if.mem_req_in_grant = (used < Q_DEPTH);

   logic accept, wr_en, rd_accept, err_inc;
   assign accept    = req_valid && mem_if.mem_req_in_grant;
   assign wr_en     = accept && req_is_write && req_in_range;
   assign rd_accept = accept && !req_is_write;
   assign err_inc   = accept && !req_in_range;

   logic [575:0] mem [DEPTH_WORDS];
   logic [575:0] rd_data_q;

   always_ff @(posedge clk) begin
      if (wr_en) mem[req_idx] <= req_data;
      if (s1_valid_q) rd_data_q <= mem[s1_idx_q];
   end

   logic [581:0] fifo_mem [RESP_Q_DEPTH];
   logic push, pop, empty;
   logic [581:0] push_entry;
   assign empty      = (count_q == '0);
   assign push       = s2_valid_q;
   assign pop        = !empty && mem_if.mem_resp_out_grant;
   assign push_entry = {(s2_oor_q ? 576'd0 : rd_data_q), s2_size_q};

   always_ff @(posedge clk) begin
      if (push) fifo_mem[wr_ptr_q] <= push_entry;
   end

   always_comb begin
      count_d = count_q;
      if (push && !pop)
         count_d = count_q + 1'b1;
      else if (!push && pop)
         count_d = count_q - 1'b1;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s1_valid_q  <= 1'b0;
         s1_oor_q    <= 1'b0;
         s1_idx_q    <= '0;
         s1_size_q   <= '0;
         s2_valid_q  <= 1'b0;
         s2_oor_q    <= 1'b0;
         s2_size_q   <= '0;
         count_q     <= '0;
         wr_ptr_q    <= '0;
         rd_ptr_q    <= '0;
         err_count_q <= '0;
      end else begin
         s1_valid_q <= rd_accept;
         s1_oor_q   <= !req_in_range;
         s1_idx_q   <= req_idx;
         s1_size_q  <= req_size;
         s2_valid_q <= s1_valid_q;
         s2_oor_q   <= s1_oor_q;
         s2_size_q  <= s1_size_q;
         count_q    <= count_d;
         if (push) wr_ptr_q <= (wr_ptr_q == PTR_LAST) ? '0 : wr_ptr_q + 1'b1;
         if (pop)  rd_ptr_q <= (rd_ptr_q == PTR_LAST) ? '0 : rd_ptr_q + 1'b1;
         if (err_inc && (err_count_q != '1))
            err_count_q <= err_count_q + 1'b1;
      end
   end

   assign mem_if.mem_resp_out = {!empty, fifo_mem[rd_ptr_q]};
   assign busy      = s1_valid_q || s2_valid_q || !empty;
   assign err_count = err_count_q;
endmodule
